// File: rtl/instruction_fetcher.sv
// Fetch front end: issues 8-byte-aligned reads to a 1-cycle synchronous memory
// and splits each returned doubleword into two program-ordered instruction slots.
module instruction_fetcher #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic [63:0] fetchedInstruction,
   output logic [31:0] instructionAddress,
   output logic [31:0] instructionA,
   output logic [31:0] instructionB,
   output logic        instructionA_valid,
   output logic        instructionB_valid,
   output logic [31:0] addressA,
   output logic [31:0] addressB
);

   logic [31:0] pc, respPc;
   logic        respValid, holdValid;
   logic [63:0] holdData, dataWord;
   logic [31:0] alignedTarget, pcDword;

   assign alignedTarget      = branchTarget & ~32'h3;
   assign pcDword            = pc & ~32'h7;
   assign instructionAddress = pcDword;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         respPc    <= RESET_PC;
         respValid <= 1'b0;
         holdValid <= 1'b0;
         holdData  <= '0;
      end else if (branchTaken) begin
         pc        <= alignedTarget;
         respValid <= 1'b0;
         holdValid <= 1'b0;
      end else if (stall) begin
         // Memory keeps reading the next address during a stall, so capture the
         // doubleword on display before it is overwritten.
         if (respValid && !holdValid) begin
            holdData  <= fetchedInstruction;
            holdValid <= 1'b1;
         end
      end else begin
         respPc    <= pc;
         respValid <= 1'b1;
         pc        <= pcDword + 32'd8;
         holdValid <= 1'b0;
      end
   end

   assign dataWord = holdValid ? holdData : fetchedInstruction;

   always_comb begin
      instructionA       = '0;
      instructionB       = '0;
      instructionA_valid = 1'b0;
      instructionB_valid = 1'b0;
      addressA           = respPc;
      addressB           = respPc + 32'd4;
      if (respValid) begin
         instructionA_valid = 1'b1;
         // Entry at the upper word after a branch leaves slot B empty.
         if (respPc[2]) begin
            instructionA = dataWord[63:32];
         end else begin
            instructionA       = dataWord[31:0];
            instructionB       = dataWord[63:32];
            instructionB_valid = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed plan then random stall/branch/reset,
// checked every cycle against a program-order model of the fetch stream.
module tb_instruction_fetcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branchTaken = 1'b0;
   logic [31:0] branchTarget = '0;
   logic [63:0] fetchedInstruction = '0;
   logic [31:0] instructionAddress, instructionA, instructionB, addressA, addressB;
   logic        instructionA_valid, instructionB_valid;

   int errors = 0;
   int checks = 0;

   // Model: the PC being shown (and whether it is real) and the next PC in program order.
   logic        mShowValid = 1'b0;
   logic [31:0] mShowPc = '0;
   logic [31:0] mNextPc = '0;

   instruction_fetcher #(.RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
      .branchTarget(branchTarget), .fetchedInstruction(fetchedInstruction),
      .instructionAddress(instructionAddress), .instructionA(instructionA),
      .instructionB(instructionB), .instructionA_valid(instructionA_valid),
      .instructionB_valid(instructionB_valid), .addressA(addressA), .addressB(addressB)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] wordAt(input logic [31:0] a);
      if (a < 32'h20) return 32'h1111_1111 * (a >> 2);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   always @(posedge clk)
      fetchedInstruction <= {wordAt(instructionAddress + 32'd4), wordAt(instructionAddress)};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare();
      logic        bValid;
      bValid = mShowValid && !mShowPc[2];
      chk("addr", instructionAddress, mNextPc & ~32'h7);
      chk("validA", {31'b0, instructionA_valid}, {31'b0, mShowValid});
      chk("validB", {31'b0, instructionB_valid}, {31'b0, bValid});
      chk("instrA", instructionA, mShowValid ? wordAt(mShowPc) : 32'h0);
      chk("instrB", instructionB, bValid ? wordAt(mShowPc + 32'd4) : 32'h0);
      if (mShowValid) begin
         chk("pcA", addressA, mShowPc);
         chk("pcB", addressB, mShowPc + 32'd4);
      end
   endtask

   task automatic step(input logic r, input logic b, input logic s, input logic [31:0] t);
      reset = r; branchTaken = b; stall = s; branchTarget = t;
      @(posedge clk);
      if (r) begin
         mShowValid = 1'b0; mShowPc = 32'h0; mNextPc = 32'h0;
      end else if (b) begin
         mShowValid = 1'b0; mNextPc = t & ~32'h3;
      end else if (!s) begin
         mShowValid = 1'b1; mShowPc = mNextPc;
         mNextPc = (mNextPc & ~32'h7) + 32'd8;
      end
      #1;
      compare();
   endtask

   initial begin
      logic [31:0] tgt;
      int          sel;
      // Reset release and straight-line fetch
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      // Branch to mid-doubleword entry
      step(0, 1, 0, 32'h14); step(0, 0, 0, 0); step(0, 0, 0, 0);
      // Stall three cycles on the 0x10 pair; data must come from the skid register
      step(0, 1, 0, 32'h10); step(0, 0, 0, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      // Branch wins over stall; bits [1:0] of the target are ignored
      step(0, 1, 1, 32'h17); step(0, 0, 1, 0); step(0, 0, 0, 0);
      // Reset while the skid register is in use
      step(0, 0, 1, 0); step(0, 0, 1, 0);
      step(1, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      // Address wrap at the top of the space
      step(0, 1, 0, 32'hFFFF_FFF8); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 1, 0, 32'hFFFF_FFFC); step(0, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 99));
         if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         else                           tgt = $urandom_range(0, 255);
         if (sel < 2)       step(1, 1'($urandom), 1'($urandom), tgt);
         else if (sel < 12) step(0, 1, 1'($urandom), tgt);
         else if (sel < 45) step(0, 0, 1, tgt);
         else               step(0, 0, 0, tgt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
